// File: rtl/corr_hist_addr_gen.sv
// Time-correlation histogram address generator: classifies start/stop events,
// maps the interval to a bin around CENTER, and queues addresses in a FIFO.
module corr_hist_addr_gen #(
  parameter int CH_W   = 2,
  parameter int INT_W  = 7,
  parameter int ADDR_W = 8,
  parameter int CENTER = 128,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [CH_W-1:0]   ch_a,
  input  logic [CH_W-1:0]   ch_b,
  input  logic [CH_W-1:0]   coinc_start,
  input  logic [CH_W-1:0]   coinc_end,
  input  logic [CH_W-1:0]   start_ch,
  input  logic [CH_W-1:0]   end_ch,
  input  logic [INT_W-1:0]  interval,
  input  logic              data_arrived,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic [CNT_W-1:0]  evt_cnt,
  output logic [CNT_W-1:0]  drop_cnt,
  input  logic              clr_cnt
);

  localparam int SW = ADDR_W + 1;
  localparam int PW = $clog2(DEPTH);
  localparam logic [SW-1:0]    CEN     = SW'(CENTER);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [PW:0]      FULL    = (PW+1)'(DEPTH);

  logic              da_q;
  logic              evt;
  logic [SW-1:0]     ival;
  logic              cls_valid;
  logic              cls_drop;
  logic [SW-1:0]     cls_res;

  logic              s1_push;
  logic              s1_drop;
  logic [ADDR_W-1:0] s1_addr;

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW:0]       count;
  logic              full;
  logic              pop;
  logic              push;
  logic              full_drop;

  assign evt  = data_arrived & en & ~da_q;
  assign ival = SW'(interval);

  // Both operands are below 2**ADDR_W, so the extra result bit is set exactly
  // when the sum overflows the address range or the difference goes negative.
  always_comb begin
    cls_valid = 1'b0;
    cls_drop  = 1'b0;
    cls_res   = '0;
    if (start_ch == coinc_start && end_ch == coinc_end && interval == '0) begin
      cls_valid = 1'b1;
      cls_res   = CEN;
    end else if (start_ch == ch_a && end_ch == ch_b) begin
      cls_res   = CEN + ival;
      cls_drop  = cls_res[ADDR_W];
      cls_valid = ~cls_res[ADDR_W];
    end else if (start_ch == ch_b && end_ch == ch_a) begin
      cls_res   = CEN - ival;
      cls_drop  = cls_res[ADDR_W];
      cls_valid = ~cls_res[ADDR_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      da_q    <= 1'b1;
      s1_push <= 1'b0;
      s1_drop <= 1'b0;
      s1_addr <= '0;
    end else begin
      da_q    <= data_arrived;
      s1_push <= evt & cls_valid;
      s1_drop <= evt & cls_drop;
      s1_addr <= cls_res[ADDR_W-1:0];
    end
  end

  assign addr_valid = (count != '0);
  assign addr       = mem[rd_ptr];
  assign full       = (count == FULL);
  assign pop        = addr_valid & addr_ready;
  assign push       = s1_push & (~full | pop);
  assign full_drop  = s1_push & full & ~pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= s1_addr;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + (PW+1)'(1);
      else if (pop && !push) count <= count - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      evt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (push && evt_cnt != CNT_MAX) evt_cnt <= evt_cnt + CNT_W'(1);
      if ((s1_drop || full_drop) && drop_cnt != CNT_MAX) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_corr_hist_addr_gen.sv
// Bench for corr_hist_addr_gen: directed scenarios plus randomized bursts
// checked against a queue-based reference model.
module tb_corr_hist_addr_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic [1:0] ch_a = 2'd1, ch_b = 2'd2, coinc_start = 2'd0, coinc_end = 2'd3;
  logic [1:0] start_ch = '0, end_ch = '0;
  logic [6:0] interval = '0;
  logic       data_arrived = 1'b0;
  logic [7:0] addr;
  logic       addr_valid;
  logic       addr_ready = 1'b0;
  logic [15:0] evt_cnt, drop_cnt;
  logic       clr_cnt = 1'b0;

  logic       da2 = 1'b0;
  logic [6:0] addr2;
  logic       valid2;
  logic [1:0] evt2, drop2;

  int vectors = 0;
  int miscompares = 0;
  int q[$];
  int exp_evt = 0;
  int exp_drop = 0;

  always #5 clk = ~clk;

  corr_hist_addr_gen #(.CH_W(2), .INT_W(7), .ADDR_W(8), .CENTER(128), .DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .ch_a(ch_a), .ch_b(ch_b),
    .coinc_start(coinc_start), .coinc_end(coinc_end),
    .start_ch(start_ch), .end_ch(end_ch), .interval(interval),
    .data_arrived(data_arrived), .addr(addr), .addr_valid(addr_valid),
    .addr_ready(addr_ready), .evt_cnt(evt_cnt), .drop_cnt(drop_cnt), .clr_cnt(clr_cnt)
  );

  corr_hist_addr_gen #(.CH_W(2), .INT_W(7), .ADDR_W(7), .CENTER(127), .DEPTH(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .ch_a(ch_a), .ch_b(ch_b),
    .coinc_start(coinc_start), .coinc_end(coinc_end),
    .start_ch(start_ch), .end_ch(end_ch), .interval(interval),
    .data_arrived(da2), .addr(addr2), .addr_valid(valid2),
    .addr_ready(1'b0), .evt_cnt(evt2), .drop_cnt(drop2), .clr_cnt(1'b0)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // 0 = ignored, 1 = binned at a, 2 = out of range
  function automatic int classify(input int s, input int e, input int i,
                                  input int center, input int nbins, output int a);
    a = 0;
    if (s == 0 && e == 3 && i == 0) begin a = center; return 1; end
    if (s == 1 && e == 2) begin a = center + i; return (a < nbins) ? 1 : 2; end
    if (s == 2 && e == 1) begin a = center - i; return (a >= 0) ? 1 : 2; end
    return 0;
  endfunction

  task automatic apply(input int s, input int e, input int i);
    start_ch = 2'(s); end_ch = 2'(e); interval = 7'(i);
    data_arrived = 1'b1;
    tick;
    data_arrived = 1'b0;
    tick;
  endtask

  // Event on the main DUT with the consumer stalled; updates the model.
  task automatic do_evt(input int s, input int e, input int i);
    int a, k;
    k = classify(s, e, i, 128, 256, a);
    apply(s, e, i);
    if (k == 1) begin
      if (q.size() < 4) begin q.push_back(a); exp_evt++; end
      else exp_drop++;
    end else if (k == 2) exp_drop++;
    chk("evt_cnt", evt_cnt, exp_evt);
    chk("drop_cnt", drop_cnt, exp_drop);
  endtask

  task automatic drain;
    for (int k = 0; k < 8 && q.size() > 0; k++) begin
      chk("drain_valid", addr_valid, 1);
      chk("drain_addr", addr, q[0]);
      addr_ready = 1'b1;
      tick;
      void'(q.pop_front());
    end
    addr_ready = 1'b0;
    chk("drain_empty", addr_valid, 0);
  endtask

  task automatic send2(input int s, input int e, input int i);
    start_ch = 2'(s); end_ch = 2'(e); interval = 7'(i);
    da2 = 1'b1;
    tick;
    da2 = 1'b0;
    tick;
  endtask

  initial begin
    // data_arrived held high through reset release must not fire
    data_arrived = 1'b1;
    repeat (3) tick;
    rst = 1'b0;
    repeat (3) tick;
    chk("rst_valid", addr_valid, 0);
    chk("rst_addr", addr, 0);
    chk("rst_evt", evt_cnt, 0);
    chk("rst_drop", drop_cnt, 0);
    data_arrived = 1'b0;
    tick;

    // forward pair
    do_evt(1, 2, 5);
    chk("fwd_valid", addr_valid, 1);
    chk("fwd_addr", addr, 133);
    chk("fwd_evt", evt_cnt, 1);
    drain;

    // reverse, coincidence, ignored
    do_evt(2, 1, 5);
    do_evt(0, 3, 0);
    do_evt(0, 3, 4);
    chk("ign_evt", evt_cnt, 3);
    drain;

    // upper boundary
    do_evt(1, 2, 127);
    chk("max_addr", addr, 255);
    drain;

    // en low suppresses the event
    en = 1'b0;
    apply(1, 2, 7);
    en = 1'b1;
    chk("en_valid", addr_valid, 0);
    chk("en_evt", evt_cnt, exp_evt);

    // stalled consumer: 6 events, 4 queued, 2 dropped
    for (int n = 0; n < 6; n++) do_evt(1, 2, 10 + n);
    chk("full_drop", drop_cnt, exp_drop);
    drain;

    // full FIFO with push and pop in the same cycle
    for (int n = 0; n < 4; n++) do_evt(2, 1, 20 + n);
    start_ch = 2'd1; end_ch = 2'd2; interval = 7'd9;
    data_arrived = 1'b1;
    tick;
    data_arrived = 1'b0;
    chk("pp_head", addr, q[0]);
    addr_ready = 1'b1;
    tick;
    addr_ready = 1'b0;
    void'(q.pop_front());
    q.push_back(137);
    exp_evt++;
    chk("pp_drop", drop_cnt, exp_drop);
    chk("pp_evt", evt_cnt, exp_evt);
    drain;

    // reset with 3 queued
    for (int n = 0; n < 3; n++) do_evt(1, 2, n);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    q.delete();
    exp_evt = 0;
    exp_drop = 0;
    chk("rst3_valid", addr_valid, 0);
    chk("rst3_evt", evt_cnt, 0);
    chk("rst3_drop", drop_cnt, 0);
    tick;

    // clr_cnt coincident with the FIFO write of an event
    do_evt(1, 2, 3);
    start_ch = 2'd2; end_ch = 2'd1; interval = 7'd3;
    data_arrived = 1'b1;
    tick;
    data_arrived = 1'b0;
    clr_cnt = 1'b1;
    tick;
    clr_cnt = 1'b0;
    q.push_back(125);
    exp_evt = 0;
    exp_drop = 0;
    chk("clr_evt", evt_cnt, 0);
    chk("clr_drop", drop_cnt, 0);
    drain;

    // randomized bursts against the model
    for (int b = 0; b < 8; b++) begin
      int nev;
      nev = $urandom_range(3, 7);
      for (int n = 0; n < nev; n++) begin
        int s, e, i;
        s = $urandom_range(0, 3);
        e = $urandom_range(0, 3);
        i = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 127);
        do_evt(s, e, i);
      end
      drain;
    end

    // narrow build: range drop, minus-path zero, saturating drop counter
    send2(1, 2, 1);
    chk("n_drop", drop2, 1);
    chk("n_valid", valid2, 0);
    send2(2, 1, 127);
    chk("n_zero_valid", valid2, 1);
    chk("n_zero_addr", addr2, 0);
    chk("n_evt", evt2, 1);
    for (int n = 0; n < 3; n++) send2(1, 2, 2 + n);
    chk("n_sat", drop2, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
